// File: rtl/uart_rx_cfg_if.sv
// Received-word handshake between uart_rx_cfg (master) and its consumer (slave).
// The receiver holds a word with its error flags until the consumer accepts it.
interface uart_rx_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic                 o_RX_DV;
  logic [DATA_BITS-1:0] o_RX_Data;
  logic                 o_parity_err;
  logic                 o_frame_err;
  logic                 o_overrun;
  logic                 i_RX_Ready;

  modport master (
    output o_RX_DV,
    output o_RX_Data,
    output o_parity_err,
    output o_frame_err,
    output o_overrun,
    input  i_RX_Ready
  );

  modport slave (
    input  o_RX_DV,
    input  o_RX_Data,
    input  o_parity_err,
    input  o_frame_err,
    input  o_overrun,
    output i_RX_Ready
  );
endinterface

// File: rtl/uart_rx_cfg.sv
// Oversampled UART receiver: parity/stop checking, held-word handshake, sticky overrun.
// Optional break detection is enabled by defining UART_RX_BREAK_DETECT_EN.
module uart_rx_cfg #(
  parameter int DATA_BITS    = 8,
  parameter int TICK_PER_BIT = 16,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic           i_Clock,
  input  logic           i_reset,
  input  logic           sample_tick,
  input  logic           i_RX,
  uart_rx_cfg_if.master  rx_if,
  output logic           o_busy,
  output logic           o_break
);

  localparam int CNT_W = $clog2(TICK_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(TICK_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(TICK_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
`ifdef UART_RX_BREAK_DETECT_EN
    , BRK_WAIT
`endif
  } state_t;

  function automatic logic parity_mismatch(input logic [DATA_BITS-1:0] d, input logic p);
    logic x;
    x = (^d) ^ p;
    if (PARITY_MODE == 1) return x;
    if (PARITY_MODE == 2) return ~x;
    return 1'b0;
  endfunction

  state_t               state_q, state_d;
  logic                 rx_meta_q, rx_sync_q;
  logic [1:0]           settle_q;
  logic                 rx_prev_q, rx_prev_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 zero_q, zero_d;
  logic                 done_q, done_d;
  logic                 dv_q, dv_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 perr_out_q, perr_out_d;
  logic                 ferr_out_q, ferr_out_d;
  logic                 ovr_q, ovr_d;
`ifdef UART_RX_BREAK_DETECT_EN
  logic                 brk_q, brk_d;
`endif

  // Synchroniser plus a settle shift so the reset value of the chain can never fake an edge
  always_ff @(posedge i_Clock or negedge i_reset) begin
    if (!i_reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      settle_q  <= 2'b00;
    end else begin
      rx_meta_q <= i_RX;
      rx_sync_q <= rx_meta_q;
      settle_q  <= {settle_q[0], 1'b1};
    end
  end

  always_ff @(posedge i_Clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= IDLE;
      rx_prev_q  <= 1'b0;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      zero_q     <= 1'b0;
      done_q     <= 1'b0;
      dv_q       <= 1'b0;
      data_q     <= '0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_prev_q  <= rx_prev_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      zero_q     <= zero_d;
      done_q     <= done_d;
      dv_q       <= dv_d;
      data_q     <= data_d;
      perr_out_q <= perr_out_d;
      ferr_out_q <= ferr_out_d;
      ovr_q      <= ovr_d;
    end
  end

`ifdef UART_RX_BREAK_DETECT_EN
  always_ff @(posedge i_Clock or negedge i_reset) begin
    if (!i_reset) brk_q <= 1'b0;
    else          brk_q <= brk_d;
  end
`endif

  // Frame FSM: everything advances on sample_tick only
  always_comb begin
    state_d   = state_q;
    rx_prev_d = rx_prev_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    zero_d    = zero_q;
    done_d    = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
    brk_d     = 1'b0;
`endif
    if (sample_tick) begin
      if (settle_q[1]) rx_prev_d = rx_sync_q;
      case (state_q)
        IDLE: begin
          if (rx_prev_q && !rx_sync_q) begin
            state_d = START;
            cnt_d   = '0;
            bit_d   = '0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
            zero_d  = 1'b1;
          end
        end
        START: begin
          if (cnt_q == CNT_HALF) begin
            cnt_d   = '0;
            state_d = rx_sync_q ? IDLE : DATA;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == CNT_MAX) begin
            cnt_d   = '0;
            shift_d = {rx_sync_q, shift_q[DATA_BITS-1:1]};
            zero_d  = zero_q & ~rx_sync_q;
            if (bit_q == DATA_LAST) begin
              bit_d   = '0;
              state_d = (PARITY_MODE != 0) ? PARITY : STOP;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        PARITY: begin
          if (cnt_q == CNT_MAX) begin
            cnt_d   = '0;
            perr_d  = parity_mismatch(shift_q, rx_sync_q);
            zero_d  = zero_q & ~rx_sync_q;
            state_d = STOP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (cnt_q == CNT_MAX) begin
            cnt_d  = '0;
            zero_d = zero_q & ~rx_sync_q;
            if (!rx_sync_q) ferr_d = 1'b1;
            if (bit_q == STOP_LAST) begin
              bit_d = '0;
`ifdef UART_RX_BREAK_DETECT_EN
              if (zero_d) begin
                state_d = BRK_WAIT;
                brk_d   = 1'b1;
              end else begin
                state_d = IDLE;
                done_d  = 1'b1;
              end
`else
              state_d = IDLE;
              done_d  = 1'b1;
`endif
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`ifdef UART_RX_BREAK_DETECT_EN
        BRK_WAIT: begin
          if (rx_sync_q) state_d = IDLE;
        end
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  // Output holding register: consume clears, a completed word loads unless it would clobber a held one
  always_comb begin
    dv_d       = dv_q;
    data_d     = data_q;
    perr_out_d = perr_out_q;
    ferr_out_d = ferr_out_q;
    ovr_d      = ovr_q;
    if (dv_q && rx_if.i_RX_Ready) begin
      dv_d  = 1'b0;
      ovr_d = 1'b0;
    end
    if (done_q) begin
      if (dv_q && !rx_if.i_RX_Ready) begin
        ovr_d = 1'b1;
      end else begin
        dv_d       = 1'b1;
        data_d     = shift_q;
        perr_out_d = perr_q;
        ferr_out_d = ferr_q;
      end
    end
  end

  assign rx_if.o_RX_DV      = dv_q;
  assign rx_if.o_RX_Data    = data_q;
  assign rx_if.o_parity_err = perr_out_q;
  assign rx_if.o_frame_err  = ferr_out_q;
  assign rx_if.o_overrun    = ovr_q;
  assign o_busy             = (state_q != IDLE);
`ifdef UART_RX_BREAK_DETECT_EN
  assign o_break            = brk_q;
`else
  assign o_break            = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: 8 data bits, 16 ticks/bit, even parity, 1 stop bit.
// sample_tick fires every second clock, so one bit time is 32 clocks.
module tb_uart_rx_cfg;
  localparam int DB       = 8;
  localparam int TPB      = 16;
  localparam int BIT_CLKS = TPB * 2;

  logic clk;
  logic rst_n;
  logic sample_tick;
  logic rx;
  logic busy;
  logic brk;
  int   n_chk   = 0;
  int   n_fail  = 0;
  int   brk_cnt = 0;
  int   brk_base;

  uart_rx_cfg_if #(.DATA_BITS(DB)) rx_if ();

  uart_rx_cfg #(
    .DATA_BITS   (DB),
    .TICK_PER_BIT(TPB),
    .PARITY_MODE (1),
    .STOP_BITS   (1)
  ) dut (
    .i_Clock    (clk),
    .i_reset    (rst_n),
    .sample_tick(sample_tick),
    .i_RX       (rx),
    .rx_if      (rx_if),
    .o_busy     (busy),
    .o_break    (brk)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    sample_tick = 1'b0;
    forever begin
      @(negedge clk);
      sample_tick = ~sample_tick;
    end
  end

  always @(posedge clk) if (brk) brk_cnt <= brk_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic stp);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(p);
    send_bit(stp);
    send_bit(1'b1);
  endtask

  task automatic pulse_ready();
    rx_if.i_RX_Ready = 1'b1;
    @(negedge clk);
    rx_if.i_RX_Ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    rx = 1'b1;
    rx_if.i_RX_Ready = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_dv",   rx_if.o_RX_DV, 0);
    chk("rst_data", rx_if.o_RX_Data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovr",  rx_if.o_overrun, 0);
    chk("rst_ferr", rx_if.o_frame_err, 0);
    rst_n = 1'b1;
    send_bit(1'b1);
    send_bit(1'b1);

    // clean frame, held until one Ready pulse
    send_frame(8'hA5, 1'b0, 1'b1);
    chk("a5_dv",   rx_if.o_RX_DV, 1);
    chk("a5_data", rx_if.o_RX_Data, 8'hA5);
    chk("a5_perr", rx_if.o_parity_err, 0);
    chk("a5_ferr", rx_if.o_frame_err, 0);
    chk("a5_busy", busy, 0);
    repeat (100) @(negedge clk);
    chk("a5_held", rx_if.o_RX_DV, 1);
    pulse_ready();
    chk("a5_consumed", rx_if.o_RX_DV, 0);

    // bad parity
    send_frame(8'h3C, 1'b1, 1'b1);
    chk("3c_data", rx_if.o_RX_Data, 8'h3C);
    chk("3c_perr", rx_if.o_parity_err, 1);
    chk("3c_ferr", rx_if.o_frame_err, 0);
    pulse_ready();
    chk("3c_consumed", rx_if.o_RX_DV, 0);

    // bad stop bit
    send_frame(8'h81, 1'b0, 1'b0);
    chk("81_dv",   rx_if.o_RX_DV, 1);
    chk("81_data", rx_if.o_RX_Data, 8'h81);
    chk("81_ferr", rx_if.o_frame_err, 1);
    chk("81_perr", rx_if.o_parity_err, 0);
    pulse_ready();

    // short low glitch is rejected in START
    rx = 1'b0;
    repeat (8) @(negedge clk);
    chk("glitch_busy_hi", busy, 1);
    rx = 1'b1;
    repeat (16 * 2) @(negedge clk);
    chk("glitch_busy_lo", busy, 0);
    chk("glitch_no_dv", rx_if.o_RX_DV, 0);

    // overrun: second word dropped, cleared by one consume
    send_frame(8'h11, 1'b0, 1'b1);
    chk("ovr_first_clean", rx_if.o_overrun, 0);
    send_frame(8'h22, 1'b0, 1'b1);
    chk("ovr_data", rx_if.o_RX_Data, 8'h11);
    chk("ovr_dv",   rx_if.o_RX_DV, 1);
    chk("ovr_flag", rx_if.o_overrun, 1);
    pulse_ready();
    chk("ovr_dv_clr",   rx_if.o_RX_DV, 0);
    chk("ovr_flag_clr", rx_if.o_overrun, 0);

    // reset mid-frame with the line held low: no output, no restart until a fresh edge
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (3 * BIT_CLKS) @(negedge clk);
    chk("mid_no_restart", busy, 0);
    chk("mid_no_dv", rx_if.o_RX_DV, 0);
    send_bit(1'b1);
    send_frame(8'h5A, 1'b0, 1'b1);
    chk("post_rst_data", rx_if.o_RX_Data, 8'h5A);
    chk("post_rst_dv", rx_if.o_RX_DV, 1);
    pulse_ready();
    chk("no_spurious_break", brk_cnt, 0);

    // line low for 12 bit times
    brk_base = brk_cnt;
    rx = 1'b0;
    repeat (12 * BIT_CLKS) @(negedge clk);
`ifdef UART_RX_BREAK_DETECT_EN
    chk("brk_busy", busy, 1);
    chk("brk_no_dv", rx_if.o_RX_DV, 0);
    chk("brk_pulses", brk_cnt - brk_base, 1);
    send_bit(1'b1);
    chk("brk_busy_lo", busy, 0);
    chk("brk_no_dv_after", rx_if.o_RX_DV, 0);
`else
    send_bit(1'b1);
    chk("zero_dv",   rx_if.o_RX_DV, 1);
    chk("zero_data", rx_if.o_RX_Data, 0);
    chk("zero_ferr", rx_if.o_frame_err, 1);
    chk("zero_perr", rx_if.o_parity_err, 0);
    chk("zero_no_break", brk_cnt - brk_base, 0);
    chk("zero_busy_lo", busy, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 SHALL provide parameter DATA_BITS, default 8, data bits per frame, legal 5..8.
REQ-002 SHALL provide parameter TICK_PER_BIT, default 16, sample_tick pulses per bit, legal 4..64, even.
REQ-003 SHALL provide parameter PARITY_MODE, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-004 SHALL provide parameter STOP_BITS, default 1, stop bits checked, legal 1 or 2.
REQ-005 SHALL have port i_Clock  input  1  clock, rising edge.
REQ-006 SHALL have port i_reset  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port sample_tick  input  1  oversample enable, one i_Clock wide.
REQ-008 SHALL have port i_RX  input  1  serial line, asynchronous, idle high.
REQ-009 SHALL have port i_RX_Ready  input  1  consumer accepts the held word.
REQ-010 SHALL have port o_RX_DV  output  1  word valid, held until accepted.
REQ-011 SHALL have port o_RX_Data  output  DATA_BITS  received word, LSB first on the line.
REQ-012 SHALL have port o_parity_err  output  1  parity mismatch on the held word.
REQ-013 SHALL have port o_frame_err  output  1  stop bit sampled low on the held word.
REQ-014 SHALL have port o_overrun  output  1  sticky: a frame was dropped.
REQ-015 SHALL have port o_busy  output  1  high whenever state is not IDLE.
REQ-016 SHALL have port o_break  output  1  break-detect pulse, one i_Clock.

Function
REQ-017 SHALL pass i_RX through a 2-flop synchroniser; all sampling SHALL use the synchronised value.
REQ-018 SHALL implement states IDLE, START, DATA, PARITY, STOP, BRK_WAIT; the state and tick counter SHALL advance only on cycles with sample_tick high.
REQ-019 SHALL leave IDLE for START on a synchronised high-to-low transition; a line that is merely held low SHALL NOT start a frame.
REQ-020 START SHALL re-sample at tick TICK_PER_BIT/2-1: low goes to DATA with counter cleared; high returns to IDLE with no output change (glitch reject).
REQ-021 DATA SHALL sample one bit every TICK_PER_BIT ticks, LSB first; after DATA_BITS samples it SHALL go to PARITY if PARITY_MODE!=0, else to STOP.
REQ-022 PARITY SHALL sample one bit; the error is set when XOR(data, parity bit) is 1 (even) or 0 (odd).
REQ-023 STOP SHALL sample STOP_BITS bits; any low sample SHALL set the frame error for the word.
REQ-024 On the cycle after the final stop sample, the word and both error flags SHALL load together into the output registers and o_RX_DV SHALL rise; the state SHALL return to IDLE.
REQ-025 A word SHALL be consumed on a cycle with o_RX_DV and i_RX_Ready both high; o_RX_DV SHALL fall on the next cycle unless a new word loads on that same cycle.
REQ-026 If a word completes while o_RX_DV is high and is not being consumed, the new word SHALL be discarded, the held word kept, and o_overrun set.
REQ-027 o_overrun SHALL clear only on the next consume handshake.
REQ-028 The tick counter width SHALL be $clog2(TICK_PER_BIT); it SHALL wrap to 0 at TICK_PER_BIT-1.

Reset
REQ-029 When i_reset is low, the block SHALL immediately set state to IDLE and clear all counters and outputs to 0; the synchroniser SHALL reset to 1.
REQ-030 Reset asserted mid-frame SHALL abandon the frame with no partial output; after release, the block SHALL require a fresh falling edge.

Configuration
REQ-031 Macro UART_RX_BREAK_DETECT_EN defined: a frame whose data, parity and stop samples are all 0 SHALL pulse o_break for one i_Clock, load no word, and enter BRK_WAIT until the synchronised line is high, then go to IDLE.
REQ-032 Macro UART_RX_BREAK_DETECT_EN undefined: o_break SHALL be tied 0, BRK_WAIT SHALL be absent, and an all-zero frame SHALL be delivered as data 0 with o_frame_err=1.

Verification (DATA_BITS=8, TICK_PER_BIT=16, PARITY_MODE=1, STOP_BITS=1)
REQ-033 Frame 0xA5 with parity 0, stop 1, i_RX_Ready low -> o_RX_Data=0xA5, o_RX_DV=1, both error flags 0, DV held until Ready pulses once, then 0 on the next cycle.
REQ-034 Frame 0x3C with parity bit 1 -> o_RX_Data=0x3C, o_parity_err=1, o_frame_err=0.
REQ-035 Frame 0x81 with stop bit 0 -> o_frame_err=1 and data 0x81 delivered.
REQ-036 Idle line low for 4 ticks, then high -> no o_RX_DV; o_busy returns to 0 within 8 ticks.
REQ-037 Frames 0x11 then 0x22 with Ready held low -> data stays 0x11 and o_overrun=1; one Ready pulse -> o_RX_DV=0 and o_overrun=0.
REQ-038 Line low for 12 bit-times -> with macro: one o_break pulse, no DV, busy until line high; without macro: data 0x00 with o_frame_err=1.
